edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Collects single-cycle rise/fall pulses from several per-channel edge detectors and turns them into one serialized stream of edge events on a valid/ready handshake. It sits between the bank of async-input edge detectors (start, reset-request and mode inputs of the SHA3-512 front end) and the single command consumer. It shares that consumer fairly among channels by round-robin arbitration. Each channel holds one pending rise and one pending fall, ordered by arrival, with sticky overflow reporting.

## Interface
- N_CH, default 4: number of edge-detector channels (2..16).
- IDX_W, default 2: width of the channel index; must equal ceil(log2(N_CH)).

- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- rise  input  N_CH  per-channel one-cycle rising-edge pulses, synchronous to clk.
- fall  input  N_CH  per-channel one-cycle falling-edge pulses, synchronous to clk.
- evt_valid  output  1  event presented.
- evt_ready  input  1  consumer accepts the event when high with evt_valid.
- evt_ch  output  IDX_W  channel index of the presented event.
- evt_is_fall  output  1  1 = falling edge, 0 = rising edge.
- overflow  output  N_CH  sticky per-channel flag: an edge was merged into an already-pending one.
- ovf_clr  input  1  one-cycle pulse that clears all overflow bits.

## Operation
- Per channel i: pend_r[i] and pend_f[i] (pending rise/fall), plus fall_first[i] (order bit).
- Set rules, evaluated every cycle:
  - rise[i] sets pend_r[i]; fall[i] sets pend_f[i].
  - When a pulse sets one bit while the other is already pending, fall_first[i] records which arrived first.
  - rise[i] and fall[i] high in the same cycle: both set; rise is treated as first.
- Merge/overflow: a pulse for a bit that is already set, and not being cleared that cycle, sets overflow[i]. The pending count stays 1 (events merge).
- Clear vs set: if a pending bit is consumed on the same edge that a new pulse of the same type arrives, the bit stays set and no overflow is raised.
- ovf_clr clears all overflow bits. An overflow set in the same cycle wins over the clear.
- FSM, two states:
  - IDLE: if any channel has pend_r or pend_f, pick a channel by round-robin. The search starts at last_grant+1 mod N_CH and takes the first channel with anything pending.
    - Within the channel: a lone pending bit is chosen; if both are pending, the earlier one by fall_first is chosen.
    - On the next edge: load evt_ch and evt_is_fall, assert evt_valid, update last_grant, go to PRESENT.
  - PRESENT: evt_valid, evt_ch and evt_is_fall are held stable until evt_valid & evt_ready.
    - On that edge: clear the presented pending bit, deassert evt_valid, return to IDLE.
    - If the other edge type of the same channel is still pending, it remains pending and competes normally.
- Presented events are never withdrawn. Pulses arriving during PRESENT only update pending and overflow state.

## Timing
- Reset values: evt_valid=0, evt_ch=0, evt_is_fall=0, overflow=0. All pend_r/pend_f/fall_first are 0, state is IDLE, last_grant=N_CH-1 (channel 0 has first priority).
- Asserting rst_n low mid-operation discards all pending events immediately, including a presented one.
- Latency: pulse sampled at edge k → pending set after k → evt_valid high after edge k+1 (2 cycles pulse-to-valid).
- Handshake at edge m → evt_valid low during cycle m+1. The next event can be valid after edge m+1.
- Maximum throughput: one event per 2 cycles.
- Outputs are registered. There is no combinational path from evt_ready to any output.

## Test plan
- Reset and single event: release rst_n, pulse rise[2] one cycle, hold evt_ready=1. Expect evt_valid high 2 cycles after the pulse with evt_ch=2, evt_is_fall=0, high for exactly 1 cycle, and overflow=0.
- Fairness: hold evt_ready=1 and keep rise[0..3] all pending (re-pulse each after grant). Expect grant order 0,1,2,3,0,1… with no channel granted twice before the others.
- Ordering: with evt_ready=0, pulse fall[1], then 3 cycles later rise[1], then set evt_ready=1. Expect events ch1 fall, then ch1 rise.
- Overflow and clear: with evt_ready=0, pulse rise[3] twice. Expect overflow=4'b1000 and a single ch3 rise event. Then pulse ovf_clr. Expect overflow=0; ovf_clr coincident with a new merge leaves overflow[3]=1.
- Backpressure: hold evt_ready=0 for 10 cycles with an event presented while pulsing other channels. Expect evt_ch and evt_is_fall stable; on accept, evt_valid drops for 1 cycle, then the next round-robin channel appears.
- Async reset mid-operation: assert rst_n low while evt_valid=1 with 3 channels pending. Expect evt_valid=0 immediately; after release, no events emerge without new pulses.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Serializes per-channel rise/fall edge pulses into one valid/ready event stream.
// Round-robin across channels; each channel holds one rise and one fall in arrival order.
//   state      | meaning
//   ST_IDLE    | nothing presented; pick next channel with pending work
//   ST_PRESENT | event held on evt_* until accepted
module edge_event_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_CH-1:0]   rise_i,
    input  logic [N_CH-1:0]   fall_i,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [IDX_W-1:0]  evt_ch_o,
    output logic              evt_is_fall_o,
    output logic [N_CH-1:0]   overflow_o,
    input  logic              ovf_clr_i
);

    typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   pend_r_q, pend_r_d;
    logic [N_CH-1:0]   pend_f_q, pend_f_d;
    logic [N_CH-1:0]   fall_first_q, fall_first_d;
    logic [N_CH-1:0]   ovf_q, ovf_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  ch_q, ch_d;
    logic              is_fall_q, is_fall_d;

    logic              hs;
    logic [N_CH-1:0]   keep_r, keep_f, ovf_set;
    logic              found;
    logic [IDX_W-1:0]  pick_ch;
    logic              pick_fall;

    assign hs = (state_q == ST_PRESENT) && evt_ready_i;

    // A bit consumed on this edge no longer counts as pending for merge/order decisions.
    always_comb begin
        keep_r       = '0;
        keep_f       = '0;
        ovf_set      = '0;
        pend_r_d     = '0;
        pend_f_d     = '0;
        fall_first_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            keep_r[i] = pend_r_q[i] && !(hs && !is_fall_q && (ch_q == IDX_W'(i)));
            keep_f[i] = pend_f_q[i] && !(hs &&  is_fall_q && (ch_q == IDX_W'(i)));
            ovf_set[i] = (rise_i[i] && keep_r[i]) || (fall_i[i] && keep_f[i]);
            pend_r_d[i] = keep_r[i] || rise_i[i];
            pend_f_d[i] = keep_f[i] || fall_i[i];
            if (keep_r[i] && keep_f[i])
                fall_first_d[i] = fall_first_q[i];
            else if (keep_f[i])
                fall_first_d[i] = 1'b1;
            else
                fall_first_d[i] = 1'b0;
        end
        ovf_d = (ovf_q & ~{N_CH{ovf_clr_i}}) | ovf_set;
    end

    always_comb begin : p_arb
        int idx;
        idx       = 0;
        found     = 1'b0;
        pick_ch   = '0;
        pick_fall = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last_q) + k) % N_CH;
            if (!found && (pend_r_q[idx] || pend_f_q[idx])) begin
                found     = 1'b1;
                pick_ch   = IDX_W'(idx);
                pick_fall = pend_f_q[idx] && (!pend_r_q[idx] || fall_first_q[idx]);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        is_fall_d = is_fall_q;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    ch_d      = pick_ch;
                    is_fall_d = pick_fall;
                    last_d    = pick_ch;
                    state_d   = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (evt_ready_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            pend_r_q     <= '0;
            pend_f_q     <= '0;
            fall_first_q <= '0;
            ovf_q        <= '0;
            last_q       <= IDX_W'(N_CH - 1);
            ch_q         <= '0;
            is_fall_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_r_q     <= pend_r_d;
            pend_f_q     <= pend_f_d;
            fall_first_q <= fall_first_d;
            ovf_q        <= ovf_d;
            last_q       <= last_d;
            ch_q         <= ch_d;
            is_fall_q    <= is_fall_d;
        end
    end

    assign evt_valid_o   = (state_q == ST_PRESENT);
    assign evt_ch_o      = ch_q;
    assign evt_is_fall_o = is_fall_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter: queue-based reference
// model with a scoreboard popped by an independent handshake monitor.
module tb_edge_event_arbiter;
    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] rise = '0, fall = '0;
    logic         ready = 1'b0, clr = 1'b0;
    logic         evt_valid, evt_is_fall;
    logic [W-1:0] evt_ch;
    logic [N-1:0] overflow;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N_CH(N), .IDX_W(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rise_i(rise), .fall_i(fall),
        .evt_valid_o(evt_valid), .evt_ready_i(ready), .evt_ch_o(evt_ch),
        .evt_is_fall_o(evt_is_fall), .overflow_o(overflow), .ovf_clr_i(clr)
    );

    int n_tests = 0, n_fail = 0;

    typedef struct { int ch; bit f; } evt_t;
    evt_t exp_q[$];

    // Reference: per channel, an arrival-ordered list of pending edge types (0 rise, 1 fall).
    int           mq[N][$];
    bit           m_busy;
    int           m_ch;
    bit           m_f;
    int           m_last;
    logic [N-1:0] m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < N; c++) mq[c].delete();
        m_busy = 0; m_ch = 0; m_f = 0; m_last = N - 1; m_ovf = '0;
        exp_q.delete();
    endfunction

    function automatic bit has(input int c, input int t);
        for (int j = 0; j < mq[c].size(); j++)
            if (mq[c][j] == t) return 1;
        return 0;
    endfunction

    function automatic void take(input int c, input int t);
        for (int j = 0; j < mq[c].size(); j++)
            if (mq[c][j] == t) begin mq[c].delete(j); return; end
    endfunction

    function automatic void m_edge();
        int c;
        if (m_busy && ready) begin
            take(m_ch, m_f ? 1 : 0);
            m_busy = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (mq[c].size() > 0) begin
                    m_ch = c; m_f = (mq[c][0] == 1); m_busy = 1; m_last = c;
                    exp_q.push_back('{c, m_f});
                    break;
                end
            end
        end
        if (clr) m_ovf = '0;
        for (int i = 0; i < N; i++) begin
            if (rise[i]) begin if (has(i, 0)) m_ovf[i] = 1'b1; else mq[i].push_back(0); end
            if (fall[i]) begin if (has(i, 1)) m_ovf[i] = 1'b1; else mq[i].push_back(1); end
        end
    endfunction

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] f, input logic rd, input logic c);
        rise = r; fall = f; ready = rd; clr = c;
        @(posedge clk);
        m_edge();
        #1;
        chk("valid", {31'd0, evt_valid}, {31'd0, m_busy});
        chk("overflow", {28'd0, overflow}, {28'd0, m_ovf});
        if (m_busy) begin
            chk("evt_ch", {30'd0, evt_ch}, m_ch);
            chk("evt_is_fall", {31'd0, evt_is_fall}, {31'd0, m_f});
        end
    endtask

    initial begin : monitor
        evt_t e;
        forever begin
            @(negedge clk);
            if (rst_n && evt_valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_unexpected: got ch=%0d fall=%0b, expected no event", evt_ch, evt_is_fall);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_ch", {30'd0, evt_ch}, e.ch);
                    chk("sb_fall", {31'd0, evt_is_fall}, {31'd0, e.f});
                end
            end
        end
    end

    initial begin : stim
        logic [N-1:0] r, f;
        m_reset();
        #12;
        chk("rst_valid", {31'd0, evt_valid}, 0);
        chk("rst_ch", {30'd0, evt_ch}, 0);
        chk("rst_fall", {31'd0, evt_is_fall}, 0);
        chk("rst_ovf", {28'd0, overflow}, 0);
        @(negedge clk); rst_n = 1'b1;

        // single event
        cyc('0, '0, 1, 0);
        cyc(4'b0100, '0, 1, 0);
        repeat (4) cyc('0, '0, 1, 0);

        // fairness with re-pulse of the channel being accepted
        cyc(4'b1111, '0, 1, 0);
        for (int i = 0; i < 20; i++)
            cyc(m_busy ? 4'(1 << m_ch) : 4'b0000, '0, 1, 0);
        repeat (10) cyc('0, '0, 1, 0);

        // ordering within a channel
        cyc('0, 4'b0010, 0, 0);
        repeat (3) cyc('0, '0, 0, 0);
        cyc(4'b0010, '0, 0, 0);
        repeat (6) cyc('0, '0, 1, 0);

        // overflow, clear, and clear colliding with a merge
        cyc(4'b1000, '0, 0, 0);
        cyc('0, '0, 0, 0);
        cyc(4'b1000, '0, 0, 0);
        repeat (2) cyc('0, '0, 0, 0);
        repeat (4) cyc('0, '0, 1, 0);
        cyc('0, '0, 0, 1);
        cyc(4'b1000, '0, 0, 0);
        cyc('0, '0, 0, 0);
        cyc(4'b1000, '0, 0, 1);
        repeat (4) cyc('0, '0, 1, 0);
        cyc('0, '0, 1, 1);

        // backpressure with other channels pulsing
        cyc(4'b0001, '0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            r = 4'($urandom_range(0, 15)) & 4'b1110;
            f = 4'($urandom_range(0, 15)) & 4'b1110;
            cyc(r, f, 0, 0);
        end
        repeat (14) cyc('0, '0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = '0; f = '0;
            for (int c = 0; c < N; c++) begin
                r[c] = ($urandom_range(0, 9) == 0);
                f[c] = ($urandom_range(0, 9) == 0);
            end
            cyc(r, f, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        repeat (20) cyc('0, '0, 1, 0);
        chk("sb_drained", exp_q.size(), 0);

        // async reset while presenting with three channels pending
        cyc(4'b0111, '0, 0, 0);
        repeat (2) cyc('0, '0, 0, 0);
        chk("pre_rst_valid", {31'd0, evt_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, evt_valid}, 0);
        m_reset();
        rise = '0; fall = '0; ready = 1'b1; clr = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (8) cyc('0, '0, 1, 0);
        chk("post_rst_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
